// File: rtl/add_pkg.sv
// Shared helpers for the pipelined adder: chunk width and configuration check.
package add_pkg;

  // Width of one pipeline chunk; guards against a zero stage count.
  function automatic int chunk_w(input int width, input int stages);
    if (stages < 1) begin
      return 0;
    end
    return width / stages;
  endfunction

  // A configuration is legal when every stage gets an equal, non-empty chunk.
  function automatic bit cfg_ok(input int width, input int stages);
    if (stages < 1 || stages > width) begin
      return 1'b0;
    end
    return (width % stages) == 0;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// Also exports the carry into its MSB so the final stage can derive signed overflow.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] c_w;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c_w    = '0;
    s_o    = '0;
    c_w[0] = c_i;
    for (int i = 0; i < CHUNK; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c_w[i];
      c_w[i+1] = (a_i[i] & b_i[i]) | (c_w[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o     = c_w[CHUNK];
  assign c_msb_o = c_w[CHUNK-1];

endmodule

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder: one CHUNK-wide slice per stage, carry registered
// between stages. Operand chunks are skewed in, sum chunks deskewed out, so a
// whole result appears STAGES enabled edges after its operands were sampled.
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("add_pipe: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_d;
  logic [STAGES-1:0] carry_q;
  logic              last_cmsb;
  logic              ovf_q;

  // Valid tag rides alongside the data, one register per stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Inter-stage carries plus the overflow flag, which is formed in the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= '0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      carry_q <= carry_d;
      ovf_q   <= last_cmsb ^ carry_d[STAGES-1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int SDEPTH = STAGES - gi;

    logic [CHUNK-1:0] a_stg;
    logic [CHUNK-1:0] b_stg;
    logic             cin_stg;
    logic [CHUNK-1:0] sum_c;
    logic             cmsb_c;
    logic [CHUNK-1:0] sum_dly_q [SDEPTH];

    if (gi == 0) begin : g_head
      assign a_stg   = a[CHUNK-1:0];
      assign b_stg   = b[CHUNK-1:0];
      assign cin_stg = ci;
    end else begin : g_skew
      logic [CHUNK-1:0] a_dly_q [gi];
      logic [CHUNK-1:0] b_dly_q [gi];

      // Delay this stage's operand chunk by gi cycles so it meets its carry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < gi; i++) begin
            a_dly_q[i] <= '0;
            b_dly_q[i] <= '0;
          end
        end else if (en) begin
          a_dly_q[0] <= a[gi*CHUNK +: CHUNK];
          b_dly_q[0] <= b[gi*CHUNK +: CHUNK];
          for (int i = 1; i < gi; i++) begin
            a_dly_q[i] <= a_dly_q[i-1];
            b_dly_q[i] <= b_dly_q[i-1];
          end
        end
      end

      assign a_stg   = a_dly_q[gi-1];
      assign b_stg   = b_dly_q[gi-1];
      assign cin_stg = carry_q[gi-1];
    end

    add_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a_i     (a_stg),
      .b_i     (b_stg),
      .c_i     (cin_stg),
      .s_o     (sum_c),
      .c_o     (carry_d[gi]),
      .c_msb_o (cmsb_c)
    );

    // Capture this chunk's sum, then hold it back until the later chunks catch up.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SDEPTH; i++) begin
          sum_dly_q[i] <= '0;
        end
      end else if (en) begin
        sum_dly_q[0] <= sum_c;
        for (int i = 1; i < SDEPTH; i++) begin
          sum_dly_q[i] <= sum_dly_q[i-1];
        end
      end
    end

    assign s[gi*CHUNK +: CHUNK] = sum_dly_q[SDEPTH-1];

    // Only the top chunk's MSB carry-in matters; it feeds the overflow flag.
    if (gi == STAGES - 1) begin : g_tail
      assign last_cmsb = cmsb_c;
    end else begin : g_mid
      logic unused_cmsb;
      assign unused_cmsb = cmsb_c;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign co        = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe: three instances (STAGES 4, 1, 16) share stimulus.
module tb_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;

  logic        ov4, co4, ovf4;
  logic [15:0] s4;
  logic        ov1, co1, ovf1;
  logic [15:0] s1;
  logic        ov16, co16, ovf16;
  logic [15:0] s16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_pipe #(.WIDTH(16), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .a(a), .b(b), .ci(ci),
    .out_valid(ov4), .s(s4), .co(co4), .ovf(ovf4)
  );

  add_pipe #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .a(a), .b(b), .ci(ci),
    .out_valid(ov1), .s(s1), .co(co1), .ovf(ovf1)
  );

  add_pipe #(.WIDTH(16), .STAGES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .a(a), .b(b), .ci(ci),
    .out_valid(ov16), .s(s16), .co(co16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 17-bit add; signed overflow from operand/result signs.
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {16'b0, c};
    v = (x[15] == y[15]) && (t[15] != x[15]);
    return {v, t[16], t[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-instance latency check around the expected output cycle.
  task automatic chk_lat(input string tag, input int c, input int lat,
                         input logic ov, input logic [15:0] sv, input logic cv, input logic fv,
                         input logic [15:0] es, input logic ec, input logic ef);
    if (c == lat) begin
      check({tag, ".valid"}, 32'(ov), 32'd1);
      check({tag, ".s"},     32'(sv), 32'(es));
      check({tag, ".co"},    32'(cv), 32'(ec));
      check({tag, ".ovf"},   32'(fv), 32'(ef));
    end else if (c == lat - 1 || c == lat + 1) begin
      check({tag, ".idle"}, 32'(ov), 32'd0);
    end
  endtask

  task automatic run_single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic cv, input logic [15:0] es, input logic ec, input logic ef);
    a        = av;
    b        = bv;
    ci       = cv;
    in_valid = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 1) begin
        in_valid = 1'b0;
        a        = 16'h1234;
        b        = 16'h4321;
        ci       = 1'b1;
      end
      chk_lat({tag, "/S4"},  c, 4,  ov4,  s4,  co4,  ovf4,  es, ec, ef);
      chk_lat({tag, "/S1"},  c, 1,  ov1,  s1,  co1,  ovf1,  es, ec, ef);
      chk_lat({tag, "/S16"}, c, 16, ov16, s16, co16, ovf16, es, ec, ef);
    end
    $display("single %s: a=%h b=%h ci=%0d expect s=%h co=%0d ovf=%0d", tag, av, bv, cv, es, ec, ef);
  endtask

  logic [15:0] st_a [3];
  logic [15:0] st_b [3];
  logic        st_c [3];
  logic [17:0] r;
  logic [15:0] oa, ob;
  logic        oc;
  int          idx;

  initial begin
    st_a = '{16'h1234, 16'hFFFF, 16'h7000};
    st_b = '{16'h4321, 16'hFFFF, 16'h1000};
    st_c = '{1'b0, 1'b1, 1'b1};

    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    ci       = 1'b0;

    // Reset state.
    repeat (2) step();
    check("reset.ov4",  32'(ov4),  32'd0);
    check("reset.s4",   32'(s4),   32'd0);
    check("reset.co4",  32'(co4),  32'd0);
    check("reset.ovf4", 32'(ovf4), 32'd0);
    check("reset.ov1",  32'(ov1),  32'd0);
    check("reset.ov16", 32'(ov16), 32'd0);
    #2 rst_n = 1'b1;
    step();

    // Single operations on all three depths.
    run_single("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_single("posov", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_single("negov", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Eight back-to-back operations through the 4-stage instance.
    for (int c = 1; c <= 14; c++) begin
      if (c <= 8) begin
        a        = 16'((c - 1) * 'h1111);
        b        = 16'h0F0F;
        ci       = 1'((c - 1) & 1);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      idx = c - 4;
      if (idx >= 0 && idx < 8) begin
        oa = 16'(idx * 'h1111);
        ob = 16'h0F0F;
        oc = 1'(idx & 1);
        r  = ref_add(oa, ob, oc);
        check("stream.valid", 32'(ov4),  32'd1);
        check("stream.s",     32'(s4),   32'(r[15:0]));
        check("stream.co",    32'(co4),  32'(r[16]));
        check("stream.ovf",   32'(ovf4), 32'(r[17]));
        $display("stream op %0d: a=%h b=%h ci=%0d s=%h co=%0d ovf=%0d", idx, oa, ob, oc, s4, co4, ovf4);
      end else begin
        check("stream.idle", 32'(ov4), 32'd0);
      end
    end
    repeat (4) step();

    // Three ops, two stalled edges mid-flight, then a one-edge hold on the last result.
    for (int c = 1; c <= 11; c++) begin
      en = !(c == 4 || c == 5 || c == 9);
      if (c <= 3) begin
        a        = st_a[c-1];
        b        = st_b[c-1];
        ci       = st_c[c-1];
        in_valid = 1'b1;
      end else if (c <= 5) begin
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        ci       = 1'b1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 6 && c <= 9) begin
        idx = (c == 9) ? 2 : c - 6;
        r   = ref_add(st_a[idx], st_b[idx], st_c[idx]);
        check("stall.valid", 32'(ov4),  32'd1);
        check("stall.s",     32'(s4),   32'(r[15:0]));
        check("stall.co",    32'(co4),  32'(r[16]));
        check("stall.ovf",   32'(ovf4), 32'(r[17]));
        $display("stall op %0d at cycle %0d: s=%h co=%0d ovf=%0d", idx, c, s4, co4, ovf4);
      end else begin
        check("stall.idle", 32'(ov4), 32'd0);
      end
    end
    en = 1'b1;
    repeat (20) step();

    // Asynchronous reset with operations in flight.
    for (int c = 1; c <= 5; c++) begin
      case (c)
        1:       begin a = 16'h0001; b = 16'h0002; ci = 1'b0; end
        2:       begin a = 16'h8000; b = 16'h8000; ci = 1'b1; end
        default: begin a = 16'hFFFF; b = 16'h0001; ci = 1'b0; end
      endcase
      in_valid = 1'b1;
      step();
    end
    check("rst.pre_valid", 32'(ov4),  32'd1);
    check("rst.pre_s",     32'(s4),   32'h0001);
    check("rst.pre_co",    32'(co4),  32'd1);
    check("rst.pre_ovf",   32'(ovf4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.async_ov4",  32'(ov4),  32'd0);
    check("rst.async_s4",   32'(s4),   32'd0);
    check("rst.async_co4",  32'(co4),  32'd0);
    check("rst.async_ovf4", 32'(ovf4), 32'd0);
    check("rst.async_ov1",  32'(ov1),  32'd0);
    step();
    check("rst.held_ov4", 32'(ov4), 32'd0);
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      check("rst.no_stale", 32'(ov4 | ov1 | ov16), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
